// File: rtl/pipe_hazard_ctrl_if.sv
// Request and response signals between the pipeline stages and the hazard controller.
// The controller side uses the slave modport; the pipeline (or a bench) uses master.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned NSTAGE    = 5,
  parameter int unsigned ISSUE_NUM = 2,
  parameter int unsigned REG_W     = 5,
  parameter int unsigned CNT_W     = 32
);
  logic [NSTAGE-1:0]          stall_req;
  logic [NSTAGE-1:0]          flush_req;
  logic [ISSUE_NUM-1:0]       id_rs1_en;
  logic [ISSUE_NUM-1:0]       id_rs2_en;
  logic [ISSUE_NUM*REG_W-1:0] id_rs1;
  logic [ISSUE_NUM*REG_W-1:0] id_rs2;
  logic [ISSUE_NUM-1:0]       ex_mem_read;
  logic [ISSUE_NUM*REG_W-1:0] ex_rd;
  logic [NSTAGE-1:0]          stall;
  logic [NSTAGE-1:0]          flush;
  logic                       pend_flush;
  logic [CNT_W-1:0]           stall_cnt;
  logic [CNT_W-1:0]           flush_cnt;

  modport master (
    output stall_req, flush_req, id_rs1_en, id_rs2_en, id_rs1, id_rs2, ex_mem_read, ex_rd,
    input  stall, flush, pend_flush, stall_cnt, flush_cnt
  );

  modport slave (
    input  stall_req, flush_req, id_rs1_en, id_rs2_en, id_rs1, id_rs2, ex_mem_read, ex_rd,
    output stall, flush, pend_flush, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Per-stage stall/flush controller: post-reset drain, load-use detection, latched
// redirects that wait out older-stage stalls, and saturating stall/flush event counters.
module pipe_hazard_ctrl #(
  parameter int unsigned NSTAGE    = 5,
  parameter int unsigned ISSUE_NUM = 2,
  parameter int unsigned REG_W     = 5,
  parameter int unsigned ID_STG    = 1,
  parameter int unsigned DRAIN_CYC = 2,
  parameter int unsigned CNT_W     = 32
) (
  input logic              clk,
  input logic              rst,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int unsigned SW = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;
  localparam int unsigned DW = $clog2(DRAIN_CYC + 1);

  typedef enum logic [1:0] {StDrain, StRun, StHold} state_e;

  state_e            state_q;
  logic [SW-1:0]     pend_q;
  logic [DW-1:0]     drain_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  flush_cnt_q;

  logic              lu;
  logic [REG_W-1:0]  rd_j;
  logic [NSTAGE-1:0] sreq;
  logic              f_valid, eff_valid, s_valid, in_hold;
  logic [SW-1:0]     f, eff, s;
  logic [NSTAGE-1:0] stall_c, flush_c;
  logic              apply, hold_next;

  always_comb begin
    lu   = 1'b0;
    rd_j = '0;
    for (int j = 0; j < ISSUE_NUM; j++) begin
      rd_j = bus.ex_rd[j*REG_W +: REG_W];
      for (int i = 0; i < ISSUE_NUM; i++) begin
        if (bus.ex_mem_read[j] && (rd_j != '0) &&
            ((bus.id_rs1_en[i] && (bus.id_rs1[i*REG_W +: REG_W] == rd_j)) ||
             (bus.id_rs2_en[i] && (bus.id_rs2[i*REG_W +: REG_W] == rd_j)))) begin
          lu = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sreq         = bus.stall_req;
    sreq[ID_STG] = sreq[ID_STG] | lu;
    in_hold      = (state_q == StHold);

    f_valid = 1'b0;
    f       = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      if (bus.flush_req[k]) begin
        f_valid = 1'b1;
        f       = SW'(k);
      end
    end

    // Oldest outstanding redirect: a latched one, or a newer one from an older stage.
    eff_valid = f_valid | in_hold;
    eff       = f;
    if (in_hold && (!f_valid || (f < pend_q))) eff = pend_q;

    // Stall requests from stages that the redirect kills are void.
    if (eff_valid) begin
      for (int k = 0; k < NSTAGE; k++) begin
        if (k <= int'(eff)) sreq[k] = 1'b0;
      end
    end

    s_valid = 1'b0;
    s       = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      if (sreq[k]) begin
        s_valid = 1'b1;
        s       = SW'(k);
      end
    end

    stall_c = '0;
    flush_c = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      if (s_valid && (k <= int'(s))) stall_c[k] = 1'b1;
      if (s_valid && (k == int'(s) + 1)) flush_c[k] = 1'b1;
    end

    apply     = eff_valid && !s_valid;
    hold_next = eff_valid && s_valid;
    if (apply) begin
      for (int k = 0; k < NSTAGE; k++) begin
        if (k < int'(eff)) flush_c[k] = 1'b1;
      end
    end

    if (state_q == StDrain) begin
      stall_c   = '1;
      flush_c   = '1;
      apply     = 1'b0;
      hold_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StDrain;
      drain_q     <= DW'(DRAIN_CYC);
      pend_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      case (state_q)
        StDrain: begin
          drain_q <= drain_q - DW'(1);
          if (drain_q == DW'(1)) state_q <= StRun;
        end
        default: begin
          state_q <= hold_next ? StHold : StRun;
          pend_q  <= hold_next ? eff : '0;
          if ((|stall_c) && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
          if (apply && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
      endcase
    end
  end

  assign bus.stall      = stall_c;
  assign bus.flush      = flush_c;
  assign bus.pend_flush = (state_q == StHold);
  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.flush_cnt  = flush_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table, hand sequences for pending redirects and
// reset, then random traffic against an integer-level reference model.
module tb_pipe_hazard_ctrl;
  localparam int N  = 5;
  localparam int I  = 2;
  localparam int R  = 5;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.NSTAGE(N), .ISSUE_NUM(I), .REG_W(R), .CNT_W(CW)) bus ();

  pipe_hazard_ctrl #(
    .NSTAGE(N), .ISSUE_NUM(I), .REG_W(R), .ID_STG(1), .DRAIN_CYC(2), .CNT_W(CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: drain cycles left, pending stage (-1 = none), counters.
  int m_drain, m_pend, m_scnt, m_fcnt;
  int n_drain, n_pend, n_scnt, n_fcnt;
  logic [N-1:0] e_stall, e_flush;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int highest(input logic [N-1:0] v);
    int h = -1;
    for (int k = 0; k < N; k++) if (v[k]) h = k;
    return h;
  endfunction

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic model_reset();
    m_drain = 2; m_pend = -1; m_scnt = 0; m_fcnt = 0;
  endtask

  task automatic model_eval();
    int f, t, s;
    logic lu;
    logic [N-1:0] req;
    n_pend = m_pend; n_scnt = m_scnt; n_fcnt = m_fcnt; n_drain = 0;
    if (m_drain > 0) begin
      e_stall = '1;
      e_flush = '1;
      n_drain = m_drain - 1;
    end else begin
      lu = 1'b0;
      for (int j = 0; j < I; j++) begin
        int rd;
        rd = int'(bus.ex_rd[j*R +: R]);
        for (int i = 0; i < I; i++) begin
          if (bus.ex_mem_read[j] && rd != 0 &&
              ((bus.id_rs1_en[i] && int'(bus.id_rs1[i*R +: R]) == rd) ||
               (bus.id_rs2_en[i] && int'(bus.id_rs2[i*R +: R]) == rd)))
            lu = 1'b1;
        end
      end
      req = bus.stall_req;
      if (lu) req[1] = 1'b1;
      f = highest(bus.flush_req);
      t = (f > m_pend) ? f : m_pend;
      s = -1;
      for (int k = t + 1; k < N; k++) if (req[k]) s = k;
      e_stall = '0;
      e_flush = '0;
      for (int k = 0; k <= s; k++) e_stall[k] = 1'b1;
      if (s >= 0 && s < N - 1) e_flush[s+1] = 1'b1;
      if (t >= 0 && s < 0) begin
        for (int k = 0; k < t; k++) e_flush[k] = 1'b1;
        n_fcnt = sat(m_fcnt + 1);
        n_pend = -1;
      end else if (t >= 0) begin
        n_pend = t;
      end
      if (e_stall != 0) n_scnt = sat(m_scnt + 1);
    end
  endtask

  // Called just after a rising edge; checks at the falling edge, then advances one cycle.
  task automatic step(input string tag, input bit use_exp, input logic [N-1:0] es,
                      input logic [N-1:0] ef);
    @(negedge clk);
    model_eval();
    chk({tag, ".stall"}, int'(bus.stall), int'(e_stall));
    chk({tag, ".flush"}, int'(bus.flush), int'(e_flush));
    chk({tag, ".pend_flush"}, int'(bus.pend_flush), (m_pend >= 0) ? 1 : 0);
    chk({tag, ".stall_cnt"}, int'(bus.stall_cnt), m_scnt);
    chk({tag, ".flush_cnt"}, int'(bus.flush_cnt), m_fcnt);
    if (use_exp) begin
      chk({tag, ".stall_tbl"}, int'(bus.stall), int'(es));
      chk({tag, ".flush_tbl"}, int'(bus.flush), int'(ef));
    end
    @(posedge clk);
    #1;
    m_drain = n_drain; m_pend = n_pend; m_scnt = n_scnt; m_fcnt = n_fcnt;
  endtask

  task automatic idle_in();
    bus.stall_req = '0; bus.flush_req = '0;
    bus.id_rs1_en = '0; bus.id_rs2_en = '0; bus.id_rs1 = '0; bus.id_rs2 = '0;
    bus.ex_mem_read = '0; bus.ex_rd = '0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    #1;
    chk({tag, ".rst_stall"}, int'(bus.stall), 5'h1f);
    chk({tag, ".rst_flush"}, int'(bus.flush), 5'h1f);
    chk({tag, ".rst_pend"}, int'(bus.pend_flush), 0);
    chk({tag, ".rst_scnt"}, int'(bus.stall_cnt), 0);
    chk({tag, ".rst_fcnt"}, int'(bus.flush_cnt), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0]   sreq, freq;
    logic [I-1:0]   mr, r1en, r2en;
    logic [I*R-1:0] rd, rs1, rs2;
    logic [N-1:0]   es, ef;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{5'b00000, 5'b00000, 2'b10, 2'b00, 2'b01, {5'd7, 5'd0}, 10'd0, {5'd0, 5'd7},
                 5'b00011, 5'b00100};
    vecs[1]  = '{5'b00000, 5'b00000, 2'b10, 2'b00, 2'b01, 10'd0, 10'd0, 10'd0,
                 5'b00000, 5'b00000};
    vecs[2]  = '{5'b00000, 5'b00100, 2'b00, 2'b00, 2'b00, 10'd0, 10'd0, 10'd0,
                 5'b00000, 5'b00011};
    vecs[3]  = '{5'b00100, 5'b00000, 2'b00, 2'b00, 2'b00, 10'd0, 10'd0, 10'd0,
                 5'b00111, 5'b01000};
    vecs[4]  = '{5'b10000, 5'b00000, 2'b00, 2'b00, 2'b00, 10'd0, 10'd0, 10'd0,
                 5'b11111, 5'b00000};
    vecs[5]  = '{5'b00010, 5'b01000, 2'b00, 2'b00, 2'b00, 10'd0, 10'd0, 10'd0,
                 5'b00000, 5'b00111};
    vecs[6]  = '{5'b00000, 5'b00000, 2'b01, 2'b10, 2'b00, {5'd0, 5'd12}, {5'd12, 5'd0}, 10'd0,
                 5'b00011, 5'b00100};
    vecs[7]  = '{5'b00000, 5'b00000, 2'b01, 2'b00, 2'b00, {5'd0, 5'd12}, {5'd12, 5'd0}, 10'd0,
                 5'b00000, 5'b00000};
    vecs[8]  = '{5'b00000, 5'b00000, 2'b00, 2'b11, 2'b11, {5'd3, 5'd3}, {5'd3, 5'd3},
                 {5'd3, 5'd3}, 5'b00000, 5'b00000};
    vecs[9]  = '{5'b00000, 5'b10001, 2'b00, 2'b00, 2'b00, 10'd0, 10'd0, 10'd0,
                 5'b00000, 5'b01111};
    vecs[10] = '{5'b00001, 5'b00000, 2'b00, 2'b00, 2'b00, 10'd0, 10'd0, 10'd0,
                 5'b00001, 5'b00010};
    vecs[11] = '{5'b01000, 5'b10000, 2'b00, 2'b00, 2'b00, 10'd0, 10'd0, 10'd0,
                 5'b00000, 5'b01111};

    idle_in();
    rst = 1'b1;
    #1;
    do_reset("init");

    // Drain: two all-ones cycles, then quiet.
    step("drain0", 1'b1, 5'h1f, 5'h1f);
    step("drain1", 1'b1, 5'h1f, 5'h1f);
    step("run0", 1'b1, 5'h00, 5'h00);

    for (int v = 0; v < 12; v++) begin
      bus.stall_req = vecs[v].sreq; bus.flush_req = vecs[v].freq;
      bus.ex_mem_read = vecs[v].mr; bus.id_rs1_en = vecs[v].r1en; bus.id_rs2_en = vecs[v].r2en;
      bus.ex_rd = vecs[v].rd; bus.id_rs1 = vecs[v].rs1; bus.id_rs2 = vecs[v].rs2;
      step($sformatf("vec%0d", v), 1'b1, vecs[v].es, vecs[v].ef);
    end
    idle_in();
    step("quiet", 1'b1, 5'h00, 5'h00);

    // Redirect at 2 waits out a 3-cycle stall at 3.
    bus.stall_req = 5'b01000; bus.flush_req = 5'b00100;
    step("hold_a0", 1'b1, 5'b01111, 5'b10000);
    bus.flush_req = '0;
    step("hold_a1", 1'b1, 5'b01111, 5'b10000);
    step("hold_a2", 1'b1, 5'b01111, 5'b10000);
    bus.stall_req = '0;
    step("hold_a3", 1'b1, 5'b00000, 5'b00011);
    step("hold_a4", 1'b1, 5'b00000, 5'b00000);

    // Pending at 2 upgraded to 3 by a newer redirect while WB stalls.
    bus.stall_req = 5'b10000; bus.flush_req = 5'b00100;
    step("hold_b0", 1'b1, 5'b11111, 5'b00000);
    bus.flush_req = 5'b01000;
    step("hold_b1", 1'b1, 5'b11111, 5'b00000);
    bus.flush_req = '0;
    step("hold_b2", 1'b1, 5'b11111, 5'b00000);
    bus.stall_req = '0;
    step("hold_b3", 1'b1, 5'b00000, 5'b00111);

    // Pending apply coinciding with a younger redirect counts once.
    bus.stall_req = 5'b10000; bus.flush_req = 5'b01000;
    step("hold_c0", 1'b0, '0, '0);
    bus.stall_req = '0; bus.flush_req = 5'b00010;
    step("hold_c1", 1'b1, 5'b00000, 5'b00111);

    // Reset in the middle of a hold.
    bus.stall_req = 5'b10000; bus.flush_req = 5'b00100;
    step("hold_d0", 1'b0, '0, '0);
    bus.flush_req = '0;
    step("hold_d1", 1'b0, '0, '0);
    do_reset("midhold");
    idle_in();
    step("post_rst0", 1'b0, '0, '0);
    step("post_rst1", 1'b0, '0, '0);

    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 99) == 0) do_reset("rnd");
      for (int k = 0; k < N; k++) begin
        bus.stall_req[k] = ($urandom_range(0, 99) < 15);
        bus.flush_req[k] = ($urandom_range(0, 99) < 8);
      end
      bus.ex_mem_read = I'($urandom_range(0, 3));
      bus.id_rs1_en   = I'($urandom_range(0, 3));
      bus.id_rs2_en   = I'($urandom_range(0, 3));
      for (int i = 0; i < I; i++) begin
        bus.ex_rd[i*R +: R]  = R'($urandom_range(0, 3));
        bus.id_rs1[i*R +: R] = R'($urandom_range(0, 3));
        bus.id_rs2[i*R +: R] = R'($urandom_range(0, 3));
      end
      step("rnd", 1'b0, '0, '0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
